// File: rtl/systolic_pkg.sv
// Types shared across the systolic array datapath blocks.
package systolic_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

endpackage : systolic_pkg

// File: rtl/piso.sv
// Parallel-in, serial-out buffer: takes one depth_p-element word per handshake
// and streams its elements, element 0 first, over a width_p-bit valid/ready port.
module piso
  import systolic_pkg::*;
#(
  parameter int width_p = 8,
  parameter int depth_p = 128
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [width_p*depth_p-1:0] data_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [width_p-1:0]         data_o,
  output logic                       last_o
);

  localparam int ptr_w_lp = $clog2(depth_p);
  localparam logic [ptr_w_lp-1:0] last_idx_lp = ptr_w_lp'(depth_p - 1);

  piso_state_e                 state_q, state_d;
  logic [ptr_w_lp-1:0]         rd_ptr_q, rd_ptr_d;
  logic [width_p*depth_p-1:0]  buf_q;

  logic in_fire;
  logic out_fire;

  assign valid_o  = (state_q == SHIFT);
  assign last_o   = valid_o & (rd_ptr_q == last_idx_lp);
  // ready_i reaches ready_o combinationally so the next word lands on the
  // same edge the last element leaves, giving back-to-back words no bubble.
  assign ready_o  = (state_q == IDLE) | (last_o & ready_i);
  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;

  assign data_o = buf_q[int'(rd_ptr_q)*width_p +: width_p];

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          state_d  = SHIFT;
          rd_ptr_d = '0;
        end
      end
      SHIFT: begin
        if (out_fire) begin
          if (last_o) begin
            // Wrap is explicit so non-power-of-two depths never overflow.
            rd_ptr_d = '0;
            state_d  = in_fire ? SHIFT : IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        rd_ptr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_ni) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the word buffer is deliberately left without reset; its contents are
  // only observed while valid_o is high, which requires a fresh load first.
  always_ff @(posedge clk_i) begin
    if (in_fire) begin
      buf_q <= data_i;
    end
  end

endmodule : piso

// File: tb/tb_piso.sv
// Directed bench for piso (width 8, depth 4): reset, single word, back-to-back,
// backpressure, mid-word reset and a deserialising round trip.
module tb_piso;

  localparam int width_p = 8;
  localparam int depth_p = 4;

  logic                       clk_i = 1'b0;
  logic                       reset_ni;
  logic                       valid_i;
  logic                       ready_o;
  logic [width_p*depth_p-1:0] data_i;
  logic                       valid_o;
  logic                       ready_i;
  logic [width_p-1:0]         data_o;
  logic                       last_o;

  int n_cmp = 0;
  int n_err = 0;

  piso #(.width_p(width_p), .depth_p(depth_p)) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_i   (data_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .data_o   (data_o),
    .last_o   (last_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance to 1 ns past the next rising edge; inputs are driven there.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_elem(input string tag, input logic [7:0] d, input logic lst);
    check({tag, ".valid"}, 32'(valid_o), 32'd1);
    check({tag, ".data"},  32'(data_o),  32'(d));
    check({tag, ".last"},  32'(last_o),  32'(lst));
  endtask

  initial begin
    logic [31:0] word_a;
    logic [31:0] word_b;
    logic [7:0]  exp_a [4];
    logic [7:0]  exp_b [4];
    logic [31:0] rt_words [4];
    logic [31:0] acc;
    int          cnt, tx, rx;
    logic        in_f, out_f;

    word_a = 32'h44332211;
    word_b = 32'h88776655;
    exp_a  = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_b  = '{8'h55, 8'h66, 8'h77, 8'h88};

    // Reset and idle
    reset_ni = 1'b0;
    valid_i  = 1'b0;
    ready_i  = 1'b0;
    data_i   = '0;
    #3;
    check("rst.valid", 32'(valid_o), 32'd0);
    check("rst.last",  32'(last_o),  32'd0);
    check("rst.ready", 32'(ready_o), 32'd1);
    tick();
    tick();
    reset_ni = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle.valid", 32'(valid_o), 32'd0);
      check("idle.ready", 32'(ready_o), 32'd1);
      check("idle.last",  32'(last_o),  32'd0);
    end

    // Single word, ready_i high
    valid_i = 1'b1;
    data_i  = word_a;
    ready_i = 1'b1;
    #1;
    check("single.accept_ready", 32'(ready_o), 32'd1);
    tick();
    valid_i = 1'b0;
    data_i  = '0;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_elem("single", exp_a[k], k == 3);
      check("single.ready_o", 32'(ready_o), 32'(k == 3));
      tick();
    end
    check("single.done_valid", 32'(valid_o), 32'd0);

    // Back-to-back words with valid_i held
    valid_i = 1'b1;
    data_i  = word_a;
    tick();
    data_i = word_b;
    #1;
    for (int k = 0; k < 8; k++) begin
      if (k < 4) check_elem("b2b", exp_a[k], k == 3);
      else       check_elem("b2b", exp_b[k-4], k == 7);
      if (k == 3) check("b2b.accept2", 32'(ready_o), 32'd1);
      if (k == 1) check("b2b.ignored", 32'(ready_o), 32'd0);
      tick();
      if (k == 3) begin
        valid_i = 1'b0;
        data_i  = '0;
        #1;
      end
    end
    check("b2b.done_valid", 32'(valid_o), 32'd0);

    // Backpressure on element 22
    valid_i = 1'b1;
    data_i  = word_a;
    tick();
    valid_i = 1'b0;
    data_i  = '0;
    #1;
    check_elem("bp.e0", 8'h11, 1'b0);
    tick();
    ready_i = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_elem("bp.stall", 8'h22, 1'b0);
      check("bp.stall_ready", 32'(ready_o), 32'd0);
      tick();
    end
    ready_i = 1'b1;
    #1;
    check_elem("bp.resume", 8'h22, 1'b0);
    tick();
    check_elem("bp.e2", 8'h33, 1'b0);
    tick();
    check_elem("bp.e3", 8'h44, 1'b1);
    tick();
    check("bp.done_valid", 32'(valid_o), 32'd0);

    // Mid-word reset while 33 is shown
    valid_i = 1'b1;
    data_i  = word_a;
    tick();
    valid_i = 1'b0;
    tick();
    tick();
    check_elem("mrst.pre", 8'h33, 1'b0);
    #2;
    reset_ni = 1'b0;
    #1;
    check("mrst.valid", 32'(valid_o), 32'd0);
    check("mrst.ready", 32'(ready_o), 32'd1);
    check("mrst.last",  32'(last_o),  32'd0);
    #2;
    reset_ni = 1'b1;
    tick();
    check("mrst.post_valid", 32'(valid_o), 32'd0);
    check("mrst.post_ready", 32'(ready_o), 32'd1);
    valid_i = 1'b1;
    data_i  = 32'hDDCCBBAA;
    tick();
    valid_i = 1'b0;
    #1;
    check_elem("mrst.first", 8'hAA, 1'b0);
    tick();
    tick();
    tick();
    tick();

    // Round trip: serialise random words under random stalls, reassemble
    for (int i = 0; i < 4; i++) rt_words[i] = $urandom;
    acc = '0;
    cnt = 0;
    tx  = 0;
    rx  = 0;
    for (int cyc = 0; cyc < 200 && rx < 4; cyc++) begin
      ready_i = 1'($urandom_range(0, 1));
      valid_i = (tx < 4);
      data_i  = (tx < 4) ? rt_words[tx] : '0;
      #1;
      in_f  = valid_i & ready_o;
      out_f = valid_o & ready_i;
      if (out_f) begin
        acc[cnt*8 +: 8] = data_o;
        cnt++;
        if (last_o) begin
          check("rt.word", acc, rt_words[rx]);
          check("rt.len",  32'(cnt), 32'd4);
          rx++;
          cnt = 0;
        end
      end
      if (in_f) tx++;
      tick();
    end
    valid_i = 1'b0;
    check("rt.words_out", 32'(rx), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_piso
